// File: rtl/ps2_key_pkg.sv
// rtl/ps2_key_pkg.sv - shared types, Set-2 constants and ASCII translation for ps2_key_event
package ps2_key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;

  localparam logic [7:0] IGN_00 = 8'h00;
  localparam logic [7:0] IGN_AA = 8'hAA;
  localparam logic [7:0] IGN_EE = 8'hEE;
  localparam logic [7:0] IGN_FA = 8'hFA;
  localparam logic [7:0] IGN_FC = 8'hFC;
  localparam logic [7:0] IGN_FD = 8'hFD;
  localparam logic [7:0] IGN_FE = 8'hFE;
  localparam logic [7:0] IGN_FF = 8'hFF;

  localparam logic [7:0] KEY_LSHIFT = 8'h12;
  localparam logic [7:0] KEY_RSHIFT = 8'h59;
  localparam logic [7:0] KEY_CAPS   = 8'h58;

  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
    logic [7:0] ascii;
  } evt_t;

  function automatic logic is_ignored(input logic [7:0] b);
    return (b == IGN_00) || (b == IGN_AA) || (b == IGN_EE) || (b == IGN_FA) ||
           (b == IGN_FC) || (b == IGN_FD) || (b == IGN_FE) || (b == IGN_FF);
  endfunction

  function automatic logic [7:0] to_ascii(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic caps);
    logic [7:0] lc;
    logic [7:0] c;
    lc = 8'h00;
    c  = 8'h00;
    case (code)
      8'h1C: lc = "a";  8'h32: lc = "b";  8'h21: lc = "c";  8'h23: lc = "d";
      8'h24: lc = "e";  8'h2B: lc = "f";  8'h34: lc = "g";  8'h33: lc = "h";
      8'h43: lc = "i";  8'h3B: lc = "j";  8'h42: lc = "k";  8'h4B: lc = "l";
      8'h3A: lc = "m";  8'h31: lc = "n";  8'h44: lc = "o";  8'h4D: lc = "p";
      8'h15: lc = "q";  8'h2D: lc = "r";  8'h1B: lc = "s";  8'h2C: lc = "t";
      8'h3C: lc = "u";  8'h2A: lc = "v";  8'h1D: lc = "w";  8'h22: lc = "x";
      8'h35: lc = "y";  8'h1A: lc = "z";
      default: lc = 8'h00;
    endcase
    if (lc != 8'h00) begin
      c = (shift ^ caps) ? (lc - 8'h20) : lc;
    end else begin
      // Digit row ignores caps lock; only shift selects the symbol
      case (code)
        8'h45: c = shift ? ")" : "0";
        8'h16: c = shift ? "!" : "1";
        8'h1E: c = shift ? "@" : "2";
        8'h26: c = shift ? "#" : "3";
        8'h25: c = shift ? "$" : "4";
        8'h2E: c = shift ? "%" : "5";
        8'h36: c = shift ? "^" : "6";
        8'h3D: c = shift ? "&" : "7";
        8'h3E: c = shift ? "*" : "8";
        8'h46: c = shift ? "(" : "9";
        8'h29: c = 8'h20;
        8'h5A: c = 8'h0D;
        8'h66: c = 8'h08;
        8'h0D: c = 8'h09;
        default: c = 8'h00;
      endcase
    end
    return ext ? 8'h00 : c;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// rtl/key_event_fifo.sv - synchronous event FIFO with valid/ready pop and sticky overflow
module key_event_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  evt_t push_data,
  input  logic pop_ready,
  output logic valid,
  output evt_t head,
  output logic overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  evt_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           pop;
  logic           wr_en;

  assign valid = (count != '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign pop   = pop_ready && valid;
  // A full FIFO still accepts a push when the head leaves in the same cycle
  assign wr_en = push && (!full || pop);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// rtl/ps2_key_event.sv - Set-2 scan-code parser producing key events into a FIFO
// Optional auto-repeat suppression when TYPEMATIC_FILTER_EN is defined.
module ps2_key_event
  import ps2_key_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PAUSE_SKIP = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] scan_byte,
  input  logic       scan_valid,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic       evt_release,
  output logic       evt_extended,
  output logic [7:0] evt_code,
  output logic [7:0] evt_ascii,
  output logic       shift_held,
  output logic       caps_lock,
  output logic       overflow
);

  localparam int SW = $clog2(PAUSE_SKIP + 1);

  state_t        state;
  logic [SW-1:0] skip_cnt;
  logic          shift_l;
  logic          shift_r;
  logic          caps_held;
  logic          emit;
  logic          emit_rel;
  logic          emit_ext;
  logic          push;
  evt_t          evt_data;
  evt_t          head;

  always_comb begin
    emit     = 1'b0;
    emit_rel = 1'b0;
    emit_ext = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: emit = (scan_byte != PFX_E0) && (scan_byte != PFX_F0) &&
                        (scan_byte != PFX_E1) && !is_ignored(scan_byte);
        ST_EXT: begin
          emit     = (scan_byte != PFX_F0) && (scan_byte != PFX_E0);
          emit_ext = 1'b1;
        end
        ST_BRK: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
        end
        ST_EXT_BRK: begin
          emit     = 1'b1;
          emit_rel = 1'b1;
          emit_ext = 1'b1;
        end
        default: emit = 1'b0;
      endcase
    end
  end

  // Translation sees the modifier state as it stood before this byte
  assign evt_data = '{rel:   emit_rel,
                      ext:   emit_ext,
                      code:  scan_byte,
                      ascii: to_ascii(scan_byte, emit_ext, shift_held, caps_lock)};

`ifdef TYPEMATIC_FILTER_EN
  logic       held_valid;
  logic [8:0] held_key;
  logic       held_match;

  assign held_match = held_valid && (held_key == {emit_ext, scan_byte});
  assign push       = emit && !(held_match && !emit_rel);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_valid <= 1'b0;
      held_key   <= '0;
    end else if (emit) begin
      if (!emit_rel) begin
        held_valid <= 1'b1;
        held_key   <= {emit_ext, scan_byte};
      end else if (held_match) begin
        held_valid <= 1'b0;
      end
    end
  end
`else
  assign push = emit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      skip_cnt  <= '0;
      shift_l   <= 1'b0;
      shift_r   <= 1'b0;
      caps_held <= 1'b0;
      caps_lock <= 1'b0;
    end else if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          if (scan_byte == PFX_E0) state <= ST_EXT;
          else if (scan_byte == PFX_F0) state <= ST_BRK;
          else if (scan_byte == PFX_E1) begin
            state    <= ST_SKIP;
            skip_cnt <= SW'(PAUSE_SKIP);
          end
        end
        ST_EXT: begin
          if (scan_byte == PFX_F0) state <= ST_EXT_BRK;
          else if (scan_byte != PFX_E0) state <= ST_IDLE;
        end
        ST_BRK, ST_EXT_BRK: state <= ST_IDLE;
        ST_SKIP: begin
          skip_cnt <= skip_cnt - 1'b1;
          if (skip_cnt <= SW'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (emit && !emit_ext) begin
        case (scan_byte)
          KEY_LSHIFT: shift_l <= !emit_rel;
          KEY_RSHIFT: shift_r <= !emit_rel;
          KEY_CAPS: begin
            if (!emit_rel && !caps_held) caps_lock <= !caps_lock;
            caps_held <= !emit_rel;
          end
          default: ;
        endcase
      end
    end
  end

  assign shift_held = shift_l || shift_r;

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (evt_data),
    .pop_ready (evt_ready),
    .valid     (evt_valid),
    .head      (head),
    .overflow  (overflow)
  );

  assign evt_release  = head.rel;
  assign evt_extended = head.ext;
  assign evt_code     = head.code;
  assign evt_ascii    = head.ascii;

endmodule

// File: tb/tb_ps2_key_event.sv
// tb/tb_ps2_key_event.sv - directed self-checking bench for ps2_key_event
module tb_ps2_key_event;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scan_byte = 8'h00;
  logic       scan_valid = 1'b0;
  logic       evt_ready = 1'b0;
  logic       evt_valid, evt_release, evt_extended, shift_held, caps_lock, overflow;
  logic [7:0] evt_code, evt_ascii;
  logic [18:0] head;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ps2_key_event #(.FIFO_DEPTH(4), .PAUSE_SKIP(7)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scan_byte    (scan_byte),
    .scan_valid   (scan_valid),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_release  (evt_release),
    .evt_extended (evt_extended),
    .evt_code     (evt_code),
    .evt_ascii    (evt_ascii),
    .shift_held   (shift_held),
    .caps_lock    (caps_lock),
    .overflow     (overflow)
  );

  // {valid, release, extended, code, ascii}
  assign head = {evt_valid, evt_release, evt_extended, evt_code, evt_ascii};

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    scan_byte  = b;
    scan_valid = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic burst(input logic [7:0] b [12], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      scan_byte  = b[i];
      scan_valid = 1'b1;
    end
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({head, shift_held, caps_lock, overflow} !== 22'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", {head, shift_held, caps_lock, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_make();
    send(8'h1C);
    checks++;
    if (head !== {3'b100, 8'h1C, 8'h61}) begin
      errors++;
      $display("FAIL single_make: got %h expected %h", head, {3'b100, 8'h1C, 8'h61});
    end
    pop_one();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_make_drained: got %b expected 0", evt_valid);
    end
  endtask

  task automatic test_shift();
    send(8'h12);
    checks++;
    if (head !== {3'b100, 8'h12, 8'h00} || shift_held !== 1'b1) begin
      errors++;
      $display("FAIL shift_make: got %h/%b expected %h/1", head, shift_held, {3'b100, 8'h12, 8'h00});
    end
    pop_one();
    send(8'h1C);
    checks++;
    if (head !== {3'b100, 8'h1C, 8'h41}) begin
      errors++;
      $display("FAIL shifted_letter: got %h expected %h", head, {3'b100, 8'h1C, 8'h41});
    end
    pop_one();
    send(8'hF0); send(8'h1C);
    checks++;
    if (head !== {3'b110, 8'h1C, 8'h41}) begin
      errors++;
      $display("FAIL shifted_break: got %h expected %h", head, {3'b110, 8'h1C, 8'h41});
    end
    pop_one();
    send(8'hF0); send(8'h12);
    checks++;
    if (head !== {3'b110, 8'h12, 8'h00} || shift_held !== 1'b0) begin
      errors++;
      $display("FAIL shift_break: got %h/%b expected %h/0", head, shift_held, {3'b110, 8'h12, 8'h00});
    end
    pop_one();
  endtask

  task automatic test_caps();
    send(8'h58);
    checks++;
    if (head !== {3'b100, 8'h58, 8'h00} || caps_lock !== 1'b1) begin
      errors++;
      $display("FAIL caps_make: got %h/%b expected %h/1", head, caps_lock, {3'b100, 8'h58, 8'h00});
    end
    pop_one();
    send(8'hF0); send(8'h58);
    pop_one();
    send(8'h1C);
    checks++;
    if (head !== {3'b100, 8'h1C, 8'h41} || caps_lock !== 1'b1) begin
      errors++;
      $display("FAIL caps_letter: got %h/%b expected %h/1", head, caps_lock, {3'b100, 8'h1C, 8'h41});
    end
    pop_one();
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if (head !== {3'b111, 8'h75, 8'h00}) begin
      errors++;
      $display("FAIL ext_break: got %h expected %h", head, {3'b111, 8'h75, 8'h00});
    end
    pop_one();
    send(8'h58); send(8'hF0); send(8'h58);
    pop_one(); pop_one();
    checks++;
    if (caps_lock !== 1'b0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL caps_toggle_off: got caps=%b valid=%b expected 0/0", caps_lock, evt_valid);
    end
  endtask

  task automatic test_pause_skip();
    burst('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'hAA, 8'hFA, 8'h00, 8'h00}, 10);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL pause_no_event: got valid=%b expected 0", evt_valid);
    end
    send(8'h29);
    checks++;
    if (head !== {3'b100, 8'h29, 8'h20}) begin
      errors++;
      $display("FAIL after_pause: got %h expected %h", head, {3'b100, 8'h29, 8'h20});
    end
    pop_one();
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_pause_single: got valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [4] = '{8'h16, 8'h1E, 8'h26, 8'h25};
    logic [7:0] chars [4] = '{8'h31, 8'h32, 8'h33, 8'h34};
    burst('{8'h16, 8'h1E, 8'h26, 8'h25, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_at_full: got %b expected 0", overflow);
    end
    send(8'h2E);
    checks++;
    if (evt_valid !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got valid=%b ovf=%b expected 1/1", evt_valid, overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (head !== {3'b100, codes[i], chars[i]}) begin
        errors++;
        $display("FAIL overflow_drain_%0d: got %h expected %h", i, head, {3'b100, codes[i], chars[i]});
      end
      pop_one();
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drained: got valid=%b expected 0", evt_valid);
    end
  endtask

  task automatic test_back_to_back_full();
    logic [7:0] codes [4] = '{8'h1D, 8'h24, 8'h2D, 8'h2C};
    logic [7:0] chars [4] = '{8'h77, 8'h65, 8'h72, 8'h74};
    burst('{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 4);
    @(negedge clk);
    scan_byte  = 8'h2C;
    scan_valid = 1'b1;
    evt_ready  = 1'b1;
    @(negedge clk);
    scan_valid = 1'b0;
    evt_ready  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (head !== {3'b100, codes[i], chars[i]}) begin
        errors++;
        $display("FAIL push_pop_full_%0d: got %h expected %h", i, head, {3'b100, codes[i], chars[i]});
      end
      pop_one();
    end
    pop_one();
    checks++;
    if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL pop_empty: got valid=%b ovf=%b expected 0/1", evt_valid, overflow);
    end
  endtask

  task automatic test_reset_mid();
    send(8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: got ovf=%b valid=%b expected 0/0", overflow, evt_valid);
    end
    rst_n = 1'b1;
    send(8'h1C);
    checks++;
    if (head !== {3'b100, 8'h1C, 8'h61}) begin
      errors++;
      $display("FAIL reset_mid_make: got %h expected %h", head, {3'b100, 8'h1C, 8'h61});
    end
    pop_one();
  endtask

  task automatic test_typematic();
`ifdef TYPEMATIC_FILTER_EN
    logic exp_rel [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int   n = 2;
`else
    logic exp_rel [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int   n = 4;
`endif
    burst('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (head !== {1'b1, exp_rel[i], 1'b0, 8'h1C, 8'h61}) begin
        errors++;
        $display("FAIL typematic_%0d: got %h expected %h", i, head, {1'b1, exp_rel[i], 1'b0, 8'h1C, 8'h61});
      end
      pop_one();
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL typematic_count: got valid=%b expected 0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_make();
    test_shift();
    test_caps();
    test_pause_skip();
    test_overflow();
    test_back_to_back_full();
    test_reset_mid();
    test_typematic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
